// File: rtl/fcoe_crc_pkg.sv
// -----------------------------------------------------------------------------
// fcoe_crc_pkg
// Shared definitions for the FCoE/Ethernet FCS logic: CRC-32 polynomial,
// default seed and good-frame residue, FSM state type and the CRC update
// functions. The CRC register is kept MSB-first (x^31 term in bit 31) while
// the data is consumed in wire order (byte lane 0 first, bit 0 of each byte
// first). This is why the data word is bit-reversed before it is folded in.
// -----------------------------------------------------------------------------
package fcoe_crc_pkg;

  localparam int               CRC_W         = 32;
  localparam logic [CRC_W-1:0] POLY          = 32'h04C1_1DB7;
  localparam logic [CRC_W-1:0] CRC_INIT_DEF  = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] RESIDUE_DEF   = 32'hC704_DD7B;
  localparam int               MIN_BYTES_DEF = 8;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_e;

  // Advance the register over one 32-bit beat: next = F(q ^ d'), where d' is
  // the beat in wire order aligned so the first wire bit meets q[31].
  function automatic logic [CRC_W-1:0] crc_upd32(input logic [CRC_W-1:0] q,
                                                 input logic [31:0]      d);
    logic [CRC_W-1:0] c;
    for (int i = 0; i < 32; i++) begin
      c[31-i] = q[31-i] ^ d[i];
    end
    for (int i = 0; i < 32; i++) begin
      c = {c[30:0], 1'b0} ^ ({CRC_W{c[31]}} & POLY);
    end
    return c;
  endfunction

  // Advance the register over one byte, bit 0 first.
  function automatic logic [CRC_W-1:0] crc_upd8(input logic [CRC_W-1:0] q,
                                                input logic [7:0]       b);
    logic [CRC_W-1:0] c;
    c = q;
    for (int i = 0; i < 8; i++) begin
      c = {c[30:0], 1'b0} ^ ({CRC_W{c[31] ^ b[i]}} & POLY);
    end
    return c;
  endfunction

endpackage

// File: rtl/fcoe_crc_chk_step.sv
// -----------------------------------------------------------------------------
// fcoe_crc_step
// Combinational next-value logic for the CRC register.
//   q       in  32  current (or seed) CRC register value
//   data    in  32  beat data, byte lane 0 first on the wire
//   nbytes  in  2   valid bytes minus 1 when full=0 (0 -> 1 byte ... 3 -> 4)
//   full    in  1   1: fold all 4 bytes with the 32-bit equations
//   crc_nxt out 32  next CRC register value
// -----------------------------------------------------------------------------
module fcoe_crc_step
  import fcoe_crc_pkg::*;
(
  input  logic [CRC_W-1:0] q,
  input  logic [31:0]      data,
  input  logic [1:0]       nbytes,
  input  logic             full,
  output logic [CRC_W-1:0] crc_nxt
);

  logic [CRC_W-1:0] s1_s, s2_s, s3_s, s4_s;

  // Byte-serial chain for a partial EOP beat: lanes 0..nbytes in order.
  always_comb begin
    s1_s = crc_upd8(q,    data[7:0]);
    s2_s = crc_upd8(s1_s, data[15:8]);
    s3_s = crc_upd8(s2_s, data[23:16]);
    s4_s = crc_upd8(s3_s, data[31:24]);
  end

  // Select between the parallel word update and the partial chain.
  always_comb begin
    crc_nxt = q;
    if (full) begin
      crc_nxt = crc_upd32(q, data);
    end else begin
      case (nbytes)
        2'd0:    crc_nxt = s1_s;
        2'd1:    crc_nxt = s2_s;
        2'd2:    crc_nxt = s3_s;
        default: crc_nxt = s4_s;
      endcase
    end
  end

endmodule

// File: rtl/fcoe_crc_chk.sv
// -----------------------------------------------------------------------------
// fcoe_crc_chk
// Receive-side FCS checker. Accumulates the CRC over every frame byte,
// including the 4-byte FCS, and compares the result against the good-frame
// residue. Passive monitor: always ready, no backpressure.
//   clk, rst          clock, synchronous active-high reset
//   in_valid/sop/eop  beat qualifiers; in_nbytes = valid bytes - 1 on EOP
//   in_data           beat data, byte lane 0 first on the wire
//   chk_valid         one-cycle verdict strobe, one cycle after the EOP beat
//   chk_ok/runt/crc/len  verdict fields, qualified by chk_valid
//   proto_err         one-cycle pulse on SOP/EOP framing violations
//   cnt_ok/cnt_bad    saturating frame counters; cnt_clr clears both
// -----------------------------------------------------------------------------
module fcoe_crc_chk
  import fcoe_crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_INIT  = CRC_INIT_DEF,
  parameter logic [CRC_W-1:0] RESIDUE   = RESIDUE_DEF,
  parameter int               MIN_BYTES = MIN_BYTES_DEF,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [1:0]       in_nbytes,
  input  logic [31:0]      in_data,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic             chk_runt,
  output logic [31:0]      chk_crc,
  output logic [15:0]      chk_len,
  output logic             proto_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_bad,
  input  logic             cnt_clr
);

  localparam logic [15:0]      MIN_LEN = 16'(MIN_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_src_s, crc_nxt_s;
  logic [15:0]      len_q, len_d, len_base_s, len_add_s, len_new_s;
  logic [16:0]      len_sum_s;
  logic             start_s, accept_s, runt_s;

  logic             chk_valid_q, chk_valid_d, chk_ok_q, chk_ok_d;
  logic             chk_runt_q, chk_runt_d, proto_err_q, proto_err_d;
  logic [31:0]      chk_crc_q, chk_crc_d;
  logic [15:0]      chk_len_q, chk_len_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d, cnt_bad_q, cnt_bad_d;

  // Beat classification, CRC seed and saturating running length. An SOP
  // always starts a fresh frame from the seed, even when it abandons one.
  always_comb begin
    start_s    = in_valid & in_sop;
    accept_s   = start_s | (in_valid & (state_q == ST_IN_FRAME));
    crc_src_s  = start_s ? CRC_INIT : crc_q;
    len_base_s = start_s ? 16'h0000 : len_q;
    len_add_s  = in_eop ? ({14'h0000, in_nbytes} + 16'd1) : 16'd4;
    len_sum_s  = {1'b0, len_base_s} + {1'b0, len_add_s};
    len_new_s  = len_sum_s[16] ? 16'hFFFF : len_sum_s[15:0];
    runt_s     = (len_new_s < MIN_LEN);
  end

  fcoe_crc_step u_step (
    .q       (crc_src_s),
    .data    (in_data),
    .nbytes  (in_nbytes),
    .full    (~in_eop),
    .crc_nxt (crc_nxt_s)
  );

  // Next-state, CRC/length accumulation and protocol-violation detection.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    proto_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid & ~in_sop) proto_err_d = 1'b1;
        else                    proto_err_d = 1'b0;
      end
      ST_IN_FRAME: begin
        if (in_valid & in_sop) proto_err_d = 1'b1;
        else                   proto_err_d = 1'b0;
      end
      default: proto_err_d = 1'b0;
    endcase
    if (accept_s) begin
      if (in_eop) begin
        state_d = ST_IDLE;
        crc_d   = CRC_INIT;
        len_d   = 16'h0000;
      end else begin
        state_d = ST_IN_FRAME;
        crc_d   = crc_nxt_s;
        len_d   = len_new_s;
      end
    end else begin
      state_d = state_q;
      crc_d   = crc_q;
      len_d   = len_q;
    end
  end

  // Verdict for an accepted EOP beat, built from the state including that beat.
  always_comb begin
    chk_valid_d = accept_s & in_eop;
    chk_ok_d    = 1'b0;
    chk_runt_d  = 1'b0;
    chk_crc_d   = 32'h0000_0000;
    chk_len_d   = 16'h0000;
    if (chk_valid_d) begin
      chk_crc_d  = crc_nxt_s;
      chk_len_d  = len_new_s;
      chk_runt_d = runt_s;
      chk_ok_d   = (crc_nxt_s == RESIDUE) & ~runt_s;
    end else begin
      chk_ok_d   = 1'b0;
    end
  end

  // Saturating frame counters; they move with the verdict register so the
  // counts shown alongside chk_valid already include that frame.
  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_bad_d = cnt_bad_q;
    if (cnt_clr) begin
      cnt_ok_d  = {CNT_W{1'b0}};
      cnt_bad_d = {CNT_W{1'b0}};
    end else if (chk_valid_d) begin
      if (chk_ok_d) begin
        if (cnt_ok_q != CNT_MAX) cnt_ok_d = cnt_ok_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else                     cnt_ok_d = cnt_ok_q;
      end else begin
        if (cnt_bad_q != CNT_MAX) cnt_bad_d = cnt_bad_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else                      cnt_bad_d = cnt_bad_q;
      end
    end else begin
      cnt_ok_d  = cnt_ok_q;
      cnt_bad_d = cnt_bad_q;
    end
  end

  // State, accumulator, verdict and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      len_q       <= 16'h0000;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      chk_runt_q  <= 1'b0;
      chk_crc_q   <= 32'h0000_0000;
      chk_len_q   <= 16'h0000;
      proto_err_q <= 1'b0;
      cnt_ok_q    <= {CNT_W{1'b0}};
      cnt_bad_q   <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
      chk_runt_q  <= chk_runt_d;
      chk_crc_q   <= chk_crc_d;
      chk_len_q   <= chk_len_d;
      proto_err_q <= proto_err_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_bad_q   <= cnt_bad_d;
    end
  end

  assign chk_valid = chk_valid_q;
  assign chk_ok    = chk_ok_q;
  assign chk_runt  = chk_runt_q;
  assign chk_crc   = chk_crc_q;
  assign chk_len   = chk_len_q;
  assign proto_err = proto_err_q;
  assign cnt_ok    = cnt_ok_q;
  assign cnt_bad   = cnt_bad_q;

endmodule

// File: tb/tb_fcoe_crc_chk.sv
// -----------------------------------------------------------------------------
// tb_fcoe_crc_chk
// Directed bench for fcoe_crc_chk. Frames are payload strings plus their
// known CRC-32 values (FCS sent little-endian); verdicts are captured by a
// negedge monitor and compared against table expectations.
// -----------------------------------------------------------------------------
module tb_fcoe_crc_chk;

  localparam logic [31:0] RES = 32'hC704_DD7B;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sop, in_eop, cnt_clr;
  logic [1:0]  in_nbytes;
  logic [31:0] in_data;
  logic        chk_valid, chk_ok, chk_runt, proto_err;
  logic [31:0] chk_crc;
  logic [15:0] chk_len, cnt_ok, cnt_bad;

  always #5 clk = ~clk;

  fcoe_crc_chk dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_nbytes(in_nbytes), .in_data(in_data), .chk_valid(chk_valid), .chk_ok(chk_ok),
    .chk_runt(chk_runt), .chk_crc(chk_crc), .chk_len(chk_len), .proto_err(proto_err),
    .cnt_ok(cnt_ok), .cnt_bad(cnt_bad), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic        ok;
    logic        runt;
    logic [31:0] crc;
    logic [15:0] len;
    logic [15:0] c_ok;
    logic [15:0] c_bad;
    int          cyc;
  } verd_t;

  typedef struct {
    string       s;
    logic [31:0] crc;
    int          bad;
    logic        ok;
    logic        runt;
    logic        res;
    logic [15:0] len;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            perr_cnt = 0;
  int            exp_cok = 0;
  int            exp_cbad = 0;
  verd_t         vq[$];
  int            eop_q[$];
  byte unsigned  fb[$];
  vec_t          tbl[9];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    verd_t v;
    if (chk_valid) begin
      v.ok = chk_ok; v.runt = chk_runt; v.crc = chk_crc; v.len = chk_len;
      v.c_ok = cnt_ok; v.c_bad = cnt_bad; v.cyc = cyc;
      vq.push_back(v);
    end
    if (proto_err) perr_cnt = perr_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [1:0] nb, input logic [31:0] d);
    @(negedge clk);
    in_valid = v; in_sop = s; in_eop = e; in_nbytes = nb; in_data = d; cnt_clr = 1'b0;
    if (v && e) eop_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic build(input string s, input logic [31:0] crc, input int bad);
    fb.delete();
    for (int i = 0; i < s.len(); i++) fb.push_back(s[i]);
    fb.push_back(crc[7:0]);   fb.push_back(crc[15:8]);
    fb.push_back(crc[23:16]); fb.push_back(crc[31:24]);
    if (bad >= 0) fb[bad] = 8'h00;
  endtask

  // Sends fb as beats; limit>=0 stops after that many beats (no EOP).
  task automatic send_frame(input int gap_max, input int limit, input logic clr_eop);
    int          n, nbeats;
    logic [31:0] d;
    logic        last;
    n = fb.size();
    nbeats = (n + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      if (limit >= 0 && b >= limit) break;
      if (b > 0 && gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      d = 32'h0;
      for (int k = 0; k < 4; k++) if (4*b + k < n) d[8*k +: 8] = fb[4*b + k];
      last = (b == nbeats - 1);
      drive(1'b1, b == 0, last, last ? 2'(n - 4*b - 1) : 2'd3, d);
      cnt_clr = clr_eop && last;
    end
  endtask

  task automatic bump(input logic ok);
    if (ok) exp_cok  = (exp_cok  == 65535) ? 65535 : exp_cok + 1;
    else    exp_cbad = (exp_cbad == 65535) ? 65535 : exp_cbad + 1;
  endtask

  task automatic check_verdict(input string nm, input logic ok, input logic runt,
                               input logic res, input logic [15:0] len);
    verd_t v;
    int    e;
    if (vq.size() == 0 || eop_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_present: got no verdict expected one", nm);
      return;
    end
    v = vq.pop_front();
    e = eop_q.pop_front();
    chk({nm, "_ok"},   32'(v.ok),   32'(ok));
    chk({nm, "_runt"}, 32'(v.runt), 32'(runt));
    chk({nm, "_len"},  32'(v.len),  32'(len));
    if (res) chk({nm, "_crc"}, v.crc, RES);
    else     chk({nm, "_crc_ne"}, 32'(v.crc != RES), 32'd1);
    chk({nm, "_cnt_ok"},  32'(v.c_ok),  32'(exp_cok));
    chk({nm, "_cnt_bad"}, 32'(v.c_bad), 32'(exp_cbad));
    chk({nm, "_latency"}, 32'(v.cyc), 32'(e + 1));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, 32'(chk_valid), 32'd0);
    chk({nm, "_ok"},    32'(chk_ok),    32'd0);
    chk({nm, "_runt"},  32'(chk_runt),  32'd0);
    chk({nm, "_crc"},   chk_crc,        32'd0);
    chk({nm, "_len"},   32'(chk_len),   32'd0);
    chk({nm, "_perr"},  32'(proto_err), 32'd0);
    chk({nm, "_cok"},   32'(cnt_ok),    32'd0);
    chk({nm, "_cbad"},  32'(cnt_bad),   32'd0);
  endtask

  task automatic clear_counters();
    @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_cok = 0; exp_cbad = 0;
    chk("clr_cok",  32'(cnt_ok),  32'd0);
    chk("clr_cbad", 32'(cnt_bad), 32'd0);
  endtask

  initial begin : main
    int p0;
    string fox;
    fox = "The quick brown fox jumps over the lazy dog";
    //            payload      crc32          bad  ok    runt  res   len
    tbl[0] = '{"123456789", 32'hCBF4_3926, -1, 1'b1, 1'b0, 1'b1, 16'd13};
    tbl[1] = '{"123456789", 32'hCBF4_3926,  5, 1'b0, 1'b0, 1'b0, 16'd13};
    tbl[2] = '{"",          32'h0000_0000, -1, 1'b0, 1'b1, 1'b1, 16'd4};
    tbl[3] = '{"a",         32'hE8B7_BE43, -1, 1'b0, 1'b1, 1'b1, 16'd5};
    tbl[4] = '{"abc",       32'h3524_41C2, -1, 1'b0, 1'b1, 1'b1, 16'd7};
    tbl[5] = '{"test",      32'hD87F_7E0C, -1, 1'b1, 1'b0, 1'b1, 16'd8};
    tbl[6] = '{"hello",     32'h3610_A686, -1, 1'b1, 1'b0, 1'b1, 16'd9};
    tbl[7] = '{fox,         32'h414F_A339, -1, 1'b1, 1'b0, 1'b1, 16'd47};
    tbl[8] = '{fox,         32'h414F_A339, 46, 1'b0, 1'b0, 1'b0, 16'd47};

    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_nbytes = 2'd0; in_data = 32'h0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Directed frame table
    for (int i = 0; i < 9; i++) begin
      build(tbl[i].s, tbl[i].crc, tbl[i].bad);
      send_frame(0, -1, 1'b0);
      idle(3);
      bump(tbl[i].ok);
      check_verdict($sformatf("vec%0d", i), tbl[i].ok, tbl[i].runt, tbl[i].res, tbl[i].len);
    end
    chk("no_extra_verdicts", 32'(vq.size()), 32'd0);

    // Non-SOP beat while idle
    p0 = perr_cnt;
    drive(1'b1, 1'b0, 1'b0, 2'd3, 32'h1234_5678);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    chk("idle_nosop_perr", 32'(proto_err), 32'd1);
    chk("idle_nosop_novalid", 32'(chk_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    chk("idle_nosop_perr_pulse", 32'(proto_err), 32'd0);
    chk("idle_nosop_perr_cnt", 32'(perr_cnt - p0), 32'd1);
    chk("idle_nosop_no_verdict", 32'(vq.size()), 32'd0);

    // SOP inside a frame abandons it; the new frame is checked normally
    p0 = perr_cnt;
    build("123456789", 32'hCBF4_3926, -1);
    send_frame(0, 2, 1'b0);
    send_frame(0, -1, 1'b0);
    idle(3);
    chk("abandon_perr_cnt", 32'(perr_cnt - p0), 32'd1);
    chk("abandon_one_verdict", 32'(vq.size()), 32'd1);
    bump(1'b1);
    check_verdict("abandon_next", 1'b1, 1'b0, 1'b1, 16'd13);

    // Ten good frames back-to-back with random gaps inside frames
    clear_counters();
    for (int f = 0; f < 10; f++) send_frame(2, -1, 1'b0);
    idle(3);
    chk("b2b_count", 32'(vq.size()), 32'd10);
    for (int f = 0; f < 10; f++) begin
      bump(1'b1);
      check_verdict($sformatf("b2b%0d", f), 1'b1, 1'b0, 1'b1, 16'd13);
    end
    chk("b2b_cnt_ok", 32'(cnt_ok), 32'd10);

    // Clear coinciding with a verdict wins over the increment
    send_frame(0, -1, 1'b1);
    idle(3);
    exp_cok = 0; exp_cbad = 0;
    check_verdict("clr_verdict", 1'b1, 1'b0, 1'b1, 16'd13);
    chk("clr_cok_after", 32'(cnt_ok), 32'd0);
    chk("clr_cbad_after", 32'(cnt_bad), 32'd0);

    // Preload cnt_bad to FFFE with single-beat runt frames, then saturate
    clear_counters();
    repeat (65534) drive(1'b1, 1'b1, 1'b1, 2'd3, 32'h0);
    idle(3);
    vq.delete(); eop_q.delete();
    exp_cbad = 65534;
    chk("preload_cbad", 32'(cnt_bad), 32'h0000_FFFE);
    chk("preload_cok", 32'(cnt_ok), 32'd0);
    build("123456789", 32'hCBF4_3926, 5);
    for (int k = 0; k < 3; k++) begin
      send_frame(0, -1, 1'b0);
      idle(3);
      bump(1'b0);
      check_verdict($sformatf("sat%0d", k), 1'b0, 1'b0, 1'b0, 16'd13);
    end
    chk("sat_cbad", 32'(cnt_bad), 32'h0000_FFFF);

    // Reset in the middle of a frame
    build("123456789", 32'hCBF4_3926, -1);
    send_frame(0, 2, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    idle(2);
    chk("midrst_no_verdict", 32'(vq.size()), 32'd0);
    eop_q.delete();
    exp_cok = 0; exp_cbad = 0;
    send_frame(0, -1, 1'b0);
    idle(3);
    bump(1'b1);
    check_verdict("after_rst", 1'b1, 1'b0, 1'b1, 16'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
